// File: rtl/clk_mon_pkg.sv
// Shared types and default parameters for the clock ratio monitor.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_ACQ   = 2'd0,
        ST_TRACK = 2'd1,
        ST_LOCK  = 2'd2
    } mon_state_e;

    localparam int unsigned DEF_CNT_W      = 8;
    localparam int unsigned DEF_EXP_HALF   = 7;
    localparam int unsigned DEF_LOCK_COUNT = 4;
    localparam int unsigned DEF_TIMEOUT    = 32;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a history flop; flags either edge of d.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic d_edge
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign d_edge = s2_q ^ s3_q;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures sig_in half-periods in clk cycles and locks onto an expected ratio.
module clk_ratio_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned EXP_HALF   = DEF_EXP_HALF,
    parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             en,
    input  logic             err_clr,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             err,
    output logic             timeout
);

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] EXP_V   = CNT_W'(EXP_HALF);
    localparam logic [CNT_W-1:0] TO_THR  = CNT_W'(TIMEOUT - 1);
    localparam logic [MW-1:0]    LOCK_V  = MW'(LOCK_COUNT);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MW-1:0]    match_q, match_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             pv_q, pv_d;
    logic             err_q, err_d;
    logic             to_q, to_d;

    logic             sig_edge;
    logic [CNT_W-1:0] cnt_inc;
    logic [MW-1:0]    match_inc;
    logic             hit;

    sync_edge_det u_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (sig_in),
        .d_edge (sig_edge)
    );

    // The edge cycle itself counts, so the interval is cnt+1.
    assign cnt_inc   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    assign match_inc = match_q + 1'b1;
    assign hit       = (cnt_inc == EXP_V);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        match_d = match_q;
        half_d  = half_q;
        pv_d    = 1'b0;
        to_d    = 1'b0;
        err_d   = err_q & ~err_clr;
        if (!en) begin
            state_d = ST_ACQ;
            cnt_d   = '0;
            match_d = '0;
        end else if (sig_edge) begin
            cnt_d = '0;
            unique case (state_q)
                ST_ACQ: begin
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    half_d = cnt_inc;
                    pv_d   = 1'b1;
                    if (hit) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_V) begin
                            state_d = ST_LOCK;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                ST_LOCK: begin
                    half_d = cnt_inc;
                    pv_d   = 1'b1;
                    if (!hit) begin
                        // A mismatch outranks a coincident err_clr.
                        err_d   = 1'b1;
                        match_d = '0;
                        state_d = ST_TRACK;
                    end
                end
                default: begin
                    state_d = ST_ACQ;
                end
            endcase
        end else if (state_q != ST_ACQ && cnt_q == TO_THR) begin
            state_d = ST_ACQ;
            to_d    = 1'b1;
            match_d = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACQ;
            cnt_q   <= '0;
            match_q <= '0;
            half_q  <= '0;
            pv_q    <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            half_q  <= half_d;
            pv_q    <= pv_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    assign half_period  = half_q;
    assign period_valid = pv_q;
    assign locked       = (state_q == ST_LOCK);
    assign err          = err_q;
    assign timeout      = to_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Directed bench for clk_ratio_monitor; sig_in driven at negedges.
module tb_clk_ratio_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       sig_in;
    logic       en;
    logic       err_clr;
    logic [7:0] half_period;
    logic       period_valid;
    logic       locked;
    logic       err;
    logic       timeout;

    int total = 0;
    int bad   = 0;
    int cyc    = 0;
    int pv_n   = 0;
    int pv_cyc = 0;
    int pv_hp  = 0;
    int to_n   = 0;
    int to_cyc = 0;
    int tog_cyc = 0;
    int pv_base = 0;
    int to_base = 0;

    always #5 clk = ~clk;

    clk_ratio_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .sig_in       (sig_in),
        .en           (en),
        .err_clr      (err_clr),
        .half_period  (half_period),
        .period_valid (period_valid),
        .locked       (locked),
        .err          (err),
        .timeout      (timeout)
    );

    // Pulse recorder: cycle index of each pulse, sampled just after the edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (period_valid === 1'b1) begin
            pv_n   = pv_n + 1;
            pv_cyc = cyc;
            pv_hp  = int'(half_period);
        end
        if (timeout === 1'b1) begin
            to_n   = to_n + 1;
            to_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic t();
        sig_in  = ~sig_in;
        tog_cyc = cyc;
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b1;
        sig_in  = 1'b0;
        err_clr = 1'b0;
        w(3);
        chk("rst_hp", 32'(half_period), 0);
        chk("rst_pv", 32'(period_valid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_timeout", 32'(timeout), 0);
        rst = 1'b0;

        // Acquire, then four 7-cycle intervals lock.
        w(7); t();
        pv_base = pv_n;
        w(7); t();
        w(3);
        chk("acq_no_pv", 32'(pv_n - pv_base), 1);
        chk("pv_latency", 32'(pv_cyc - tog_cyc), 3);
        chk("pv_pulse", 32'(period_valid), 1);
        chk("hp_7", 32'(half_period), 7);
        w(4); t();
        w(7); t();
        w(3);
        chk("no_lock_3", 32'(locked), 0);
        chk("pv_count3", 32'(pv_n - pv_base), 3);
        w(4); t();
        w(3);
        chk("lock_4", 32'(locked), 1);
        chk("hp_last7", 32'(pv_hp), 7);
        chk("err_clean", 32'(err), 0);

        // Interval of 9 while locked.
        w(6); t();
        w(3);
        chk("err_set", 32'(err), 1);
        chk("unlock", 32'(locked), 0);
        chk("hp_9", 32'(half_period), 9);
        w(4); t();
        w(7); t();
        w(7); t();
        w(3);
        chk("relock_pending", 32'(locked), 0);
        w(4); t();
        w(3);
        chk("relock", 32'(locked), 1);
        chk("err_sticky", 32'(err), 1);

        err_clr = 1'b1; w(1); err_clr = 1'b0;
        chk("err_clr", 32'(err), 0);

        // Interval of 5 with err_clr on the same cycle.
        w(1); t();
        w(2);
        err_clr = 1'b1; w(1); err_clr = 1'b0;
        chk("clr_vs_mismatch", 32'(err), 1);
        chk("hp_5", 32'(half_period), 5);
        chk("unlock2", 32'(locked), 0);
        err_clr = 1'b1; w(1); err_clr = 1'b0;
        chk("err_clr2", 32'(err), 0);

        // Relock, then hold sig_in for 40 cycles.
        w(3); t();
        w(7); t();
        w(7); t();
        w(7); t();
        w(3);
        chk("lock3", 32'(locked), 1);
        to_base = to_n;
        pv_base = pv_n;
        w(37);
        chk("to_count", 32'(to_n - to_base), 1);
        chk("to_at_32", 32'(to_cyc - tog_cyc), 35);
        chk("to_unlock", 32'(locked), 0);
        chk("to_hp_kept", 32'(half_period), 7);
        chk("to_pulse_low", 32'(timeout), 0);
        t();
        w(5);
        chk("acq_after_to", 32'(pv_n - pv_base), 0);

        // Reset in the middle of a tracking interval.
        w(2); t();
        w(6);
        pv_base = pv_n;
        to_base = to_n;
        rst    = 1'b1;
        sig_in = 1'b0;
        w(1);
        chk("mrst_hp", 32'(half_period), 0);
        chk("mrst_pv", 32'(period_valid), 0);
        chk("mrst_locked", 32'(locked), 0);
        chk("mrst_timeout", 32'(timeout), 0);
        w(2);
        rst = 1'b0;
        chk("mrst_no_pulse", 32'((pv_n - pv_base) + (to_n - to_base)), 0);

        // Disable for 10 cycles while sig_in keeps toggling.
        w(5); t();
        w(7); t();
        w(3);
        chk("post_rst_hp", 32'(half_period), 7);
        pv_base = pv_n;
        en = 1'b0;
        w(4); t();
        w(3);
        chk("dis_no_pv", 32'(pv_n - pv_base), 0);
        chk("dis_hp_kept", 32'(half_period), 7);
        chk("dis_unlocked", 32'(locked), 0);
        w(3);
        en = 1'b1;
        w(1); t();
        w(3);
        chk("en_acq_no_pv", 32'(pv_n - pv_base), 0);
        w(4); t();
        w(3);
        chk("en_first_pv", 32'(pv_n - pv_base), 1);
        chk("en_hp7", 32'(half_period), 7);
        w(4); t();
        w(7); t();
        w(3);
        chk("en_no_lock3", 32'(locked), 0);
        w(4); t();
        w(3);
        chk("en_lock4", 32'(locked), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_ratio_monitor.md
CLK_RATIO_MONITOR -- requirements
Module: clk_ratio_monitor

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of the measurement counter and of half_period.
REQ-002 Parameter EXP_HALF, default 7, SHALL be the expected half-period of sig_in in clk cycles.
REQ-003 Parameter LOCK_COUNT, default 4, SHALL be the number of consecutive matching half-periods needed to lock.
REQ-004 Parameter TIMEOUT, default 32, SHALL be the edge-free cycle count that forces re-acquisition; TIMEOUT SHALL satisfy EXP_HALF < TIMEOUT <= 2**CNT_W-1.
REQ-005 clk  input  1  sole clock; all logic is rising-edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 sig_in  input  1  asynchronous divided-clock signal under test.
REQ-008 en  input  1  monitor enable; low forces re-acquisition.
REQ-009 err_clr  input  1  single-cycle clear of sticky err.
REQ-010 half_period  output  CNT_W  last measured edge-to-edge interval in clk cycles.
REQ-011 period_valid  output  1  one-cycle pulse when half_period updates.
REQ-012 locked  output  1  high while in LOCK state.
REQ-013 err  output  1  sticky: a mismatch occurred while locked.
REQ-014 timeout  output  1  one-cycle pulse on a timeout event.

Function
REQ-015 sig_in SHALL pass through a two-flop synchronizer (s1, s2) plus a history flop s3; edge = s2 XOR s3 (both polarities).
REQ-016 cnt SHALL clear on an edge cycle, otherwise increment, saturating at 2**CNT_W-1.
REQ-017 Measured interval SHALL be cnt+1 at the edge cycle, so a toggle every 7 clk cycles measures 7.
REQ-018 States SHALL be ACQUIRE, TRACK, LOCK; reset and en=0 enter ACQUIRE.
REQ-019 ACQUIRE: first edge -> TRACK, cnt cleared, no period_valid (no reference edge).
REQ-020 TRACK: each edge loads half_period and pulses period_valid on the next cycle (registered, 1-cycle latency from edge).
REQ-021 TRACK: interval == EXP_HALF increments match_cnt; mismatch clears it; match_cnt reaching LOCK_COUNT -> LOCK in the same update.
REQ-022 LOCK: matching edge stays in LOCK; mismatch sets err, clears match_cnt, returns to TRACK; locked drops on the following cycle.
REQ-023 Any state except ACQUIRE: cnt reaching TIMEOUT-1 with no edge -> ACQUIRE, timeout pulses once, match_cnt cleared, half_period retained.
REQ-024 An edge and timeout threshold in the same cycle: the edge takes priority, no timeout.
REQ-025 err_clr clears err; if a LOCK mismatch coincides with err_clr, err SHALL remain set.
REQ-026 en=0: cnt and match_cnt cleared, synchronizer keeps running, err and half_period retained; en rising SHALL NOT create a spurious edge.
REQ-027 locked SHALL be decoded from the registered state, glitch-free.

Reset
REQ-028 rst SHALL set state=ACQUIRE, cnt=0, match_cnt=0, s1=s2=s3=0, half_period=0, period_valid=0, locked=0, err=0, timeout=0.
REQ-029 rst asserted mid-measurement SHALL abort it with no period_valid or timeout pulse.

Structure
REQ-030 Package clk_mon_pkg SHALL hold the state enum and default parameter constants.
REQ-031 Sub-module sync_edge_det (synchronizer + edge detect, ports clk, rst, d, edge) SHALL be instantiated once.

Verification
REQ-032 sig_in toggling every 7 cycles -> half_period=7 on every period_valid; locked=1 after the 4th matching measurement.
REQ-033 Locked, then one interval of 9 -> err=1, locked=0, half_period=9; after 4 further intervals of 7 -> locked=1, err still 1.
REQ-034 sig_in held constant 40 cycles after lock -> single timeout pulse at 32 edge-free cycles, state ACQUIRE, next edge gives no period_valid.
REQ-035 err_clr pulsed in the same cycle as a locked mismatch -> err remains 1; err_clr alone later -> err=0.
REQ-036 rst asserted 3 cycles into a TRACK interval -> all outputs at reset values the next cycle; no pulse emitted.
REQ-037 en low for 10 cycles with sig_in running, then high -> ACQUIRE restart, first valid measurement after the second edge, lock after 4 matches.
